interp_view_ctrl: RTL and testbench
===================================

Name: interp_view_ctrl

Overview:
Control block that sequences the image-interpolation demo. It conditions the user buttons and moves the 4x4 tile cursor over the 400x400 source image. On select, it launches the interpolation engine for the chosen 100x100 tile over a req/ack/done handshake. When the engine finishes, it switches the VGA pixel mux from source-image-with-grid view to interpolated view, and returns on the back button. It drives pos_cursor and start into the pixel-colour block and tile origin into the interpolation engine.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable samples required before a button level is accepted (10 ms at 50 MHz)
TILE_PX, 100, tile edge in source-image pixels
GRID_N, 4, tiles per row/column
TIMEOUT_CYCLES, 50000000, max cycles in WAIT_DONE before abort (1 s at 50 MHz)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high; reset reset, synchronous, active-high
btn_right  in  1  raw asynchronous button, active-high; move cursor one column right
btn_down  in  1  raw asynchronous button, active-high; move cursor one row down
btn_sel  in  1  raw asynchronous button, active-high; launch interpolation of the cursor tile
btn_back  in  1  raw asynchronous button, active-high; leave interpolated view
interp_req  out  1  request to interpolation engine
interp_ack  in  1  engine accepted request; tile origin has been sampled
interp_done  in  1  single-cycle pulse: interpolated buffer complete
tile_x0  out  10  source-image x origin of selected tile (col*TILE_PX)
tile_y0  out  10  source-image y origin of selected tile (row*TILE_PX)
pos_cursor  out  4  row*4+col, to pixel-colour block
start  out  1  1 = show interpolated view, 0 = grid/cursor view
busy  out  1  high in LAUNCH and WAIT_DONE
err  out  1  sticky timeout flag; cleared on next accepted sel or reset

Behaviour:
- Button path per input: 2-flop synchroniser -> debounce counter (accepted level changes after DEBOUNCE_CYCLES equal samples) -> rising-edge detect -> one-cycle pulse. Holding a button produces exactly one pulse.
- Cursor held as row[1:0], col[1:0]; pos_cursor = {row,col}, registered.
- FSM states: SELECT, LAUNCH, WAIT_DONE, SHOW.
- SELECT:
  - right pulse: col = col+1, with 3 wrapping to 0 and row unchanged.
  - down pulse: row = row+1, with 3 wrapping to 0 and col unchanged.
  - right and down in the same cycle: both apply.
  - sel pulse: latch tile_x0/tile_y0 from the current row/col; clear err; go to LAUNCH. Any move pulse in the same cycle is discarded.
  - back pulse: ignored.
- LAUNCH: interp_req=1, held steady until a cycle with interp_ack=1. In that cycle, go to WAIT_DONE and drop interp_req on the next cycle. tile_x0/y0 stay stable while req is high.
- WAIT_DONE: a cycle counter starts at 0. An interp_done pulse goes to SHOW.
  - If the counter reaches TIMEOUT_CYCLES-1 without done: set err, go to SELECT.
  - done and timeout in the same cycle: done wins.
- SHOW: start=1. back pulse goes to SELECT (start=0 the next cycle).
- Button pulses other than those listed are ignored in LAUNCH/WAIT_DONE/SHOW; the cursor does not move. interp_done outside WAIT_DONE is ignored.
- start = (state==SHOW); busy = (state==LAUNCH or WAIT_DONE); all outputs registered, 1-cycle latency from qualifying pulse.
- Width rule: tile_x0 = col*TILE_PX computed in 10 bits; max 300 fits.
- Reset values (any state, including mid-handshake):
  - state=SELECT, row=col=0, pos_cursor=0, tile_x0=tile_y0=0.
  - interp_req=0, start=0, busy=0, err=0.
  - Debounce counters and accepted levels cleared to 0.
  - The interpolation engine shares the same reset, so no handshake cleanup is needed.

Decomposition:
- Package interp_view_pkg:
  - state enum (SELECT, LAUNCH, WAIT_DONE, SHOW)
  - GRID_N, TILE_PX
  - display-window constants IMG_X0=120, IMG_Y0=40, IMG_W=400
  - INTERP_X0=220, INTERP_Y0=140, INTERP_W=200
  - pixel-colour and address-generator blocks share this package.
- Sub-module button_conditioner (synchroniser + debounce + edge pulse, parameter DEBOUNCE_CYCLES), instantiated four times.

Test Plan:
(All with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64.)
1. Reset, then right held 20 cycles -> exactly one pulse, pos_cursor 0->1. Three more right presses -> 2,3,0 (wrap within row). Bounce shorter than 4 cycles -> no move.
2. From pos 0: down x2, right x3 -> pos_cursor=11. sel -> tile_x0=300, tile_y0=200, busy=1, interp_req=1. ack after 5 cycles -> req falls next cycle.
3. sel and right coincident at pos 5 -> tile_x0=100, tile_y0=100, pos stays 5. Moves during WAIT_DONE/SHOW leave pos_cursor unchanged.
4. done pulse 10 cycles after ack -> start=1, busy=0. back -> start=0, state SELECT, pos_cursor retains 5.
5. No done for 64 cycles -> err=1, busy=0, start=0. done and timeout on the same cycle -> SHOW, err=0. Next sel clears err.
6. reset asserted during LAUNCH with req high -> next cycle req=0, pos_cursor=0, start=0, err=0; a spurious done afterwards is ignored.

Source files
------------

// File: rtl/interp_view_pkg.sv
// Shared types and constants for the image-interpolation demo blocks.
package interp_view_pkg;

    typedef enum logic [1:0] {
        SELECT    = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        SHOW      = 2'd3
    } view_state_e;

    // Tile grid over the 400x400 source image
    localparam int unsigned GRID_N  = 4;
    localparam int unsigned TILE_PX = 100;

    // Display window placement (source view)
    localparam int unsigned IMG_X0 = 120;
    localparam int unsigned IMG_Y0 = 40;
    localparam int unsigned IMG_W  = 400;

    // Display window placement (interpolated view)
    localparam int unsigned INTERP_X0 = 220;
    localparam int unsigned INTERP_Y0 = 140;
    localparam int unsigned INTERP_W  = 200;

    // Source-image origin of a tile index; largest result (300) fits in 10 bits
    function automatic logic [9:0] tile_origin(input logic [1:0] idx);
        return 10'(idx) * 10'(TILE_PX);
    endfunction

endpackage

// File: rtl/interp_view_ctrl_button_conditioner.sv
// Raw button -> 2-flop synchroniser -> debounce -> one-cycle rising-edge pulse.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d, level_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Two-stage synchroniser for the asynchronous button input
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Debounce state and delayed level for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
        end
    end

    assign pulse_o = level_q & ~level_prev_q;

endmodule

// File: rtl/interp_view_ctrl.sv
// Cursor movement, interpolation launch handshake and view switching.
module interp_view_ctrl
    import interp_view_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned TIMEOUT_CYCLES  = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_right,
    input  logic       btn_down,
    input  logic       btn_sel,
    input  logic       btn_back,
    output logic       interp_req,
    input  logic       interp_ack,
    input  logic       interp_done,
    output logic [9:0] tile_x0,
    output logic [9:0] tile_y0,
    output logic [3:0] pos_cursor,
    output logic       start,
    output logic       busy,
    output logic       err
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]    GRID_LAST = 2'(GRID_N - 1);

    logic right_p, down_p, sel_p, back_p;

    view_state_e   state_q, state_d;
    logic [1:0]    row_q, row_d, col_q, col_d;
    logic [9:0]    tx_q, tx_d, ty_q, ty_d;
    logic          err_q, err_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [3:0]    pos_q;
    logic          req_q, start_q, busy_q;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_right (
        .clk(clk), .reset(reset), .btn_i(btn_right), .pulse_o(right_p)
    );
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_down (
        .clk(clk), .reset(reset), .btn_i(btn_down), .pulse_o(down_p)
    );
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_sel (
        .clk(clk), .reset(reset), .btn_i(btn_sel), .pulse_o(sel_p)
    );
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_back (
        .clk(clk), .reset(reset), .btn_i(btn_back), .pulse_o(back_p)
    );

    // Next-state, cursor, tile origin, timeout and error logic
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        tx_d    = tx_q;
        ty_d    = ty_q;
        err_d   = err_q;
        tmo_d   = '0;
        case (state_q)
            SELECT: begin
                if (sel_p) begin
                    // select takes priority; coincident moves are dropped
                    tx_d    = tile_origin(col_q);
                    ty_d    = tile_origin(row_q);
                    err_d   = 1'b0;
                    state_d = LAUNCH;
                end else begin
                    if (right_p) col_d = (col_q == GRID_LAST) ? 2'd0 : col_q + 2'd1;
                    if (down_p)  row_d = (row_q == GRID_LAST) ? 2'd0 : row_q + 2'd1;
                end
            end
            LAUNCH: begin
                if (interp_ack) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (interp_done) begin
                    state_d = SHOW;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = SELECT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            SHOW: begin
                if (back_p) state_d = SELECT;
            end
            default: state_d = SELECT;
        endcase
    end

    // State and registered outputs, all derived from next-state values
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SELECT;
            row_q   <= '0;
            col_q   <= '0;
            tx_q    <= '0;
            ty_q    <= '0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
            pos_q   <= '0;
            req_q   <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            pos_q   <= {row_d, col_d};
            req_q   <= (state_d == LAUNCH);
            start_q <= (state_d == SHOW);
            busy_q  <= (state_d == LAUNCH) || (state_d == WAIT_DONE);
        end
    end

    assign interp_req = req_q;
    assign tile_x0    = tx_q;
    assign tile_y0    = ty_q;
    assign pos_cursor = pos_q;
    assign start      = start_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule

// File: tb/tb_interp_view_ctrl.sv
// Directed bench for interp_view_ctrl with short debounce and timeout.
module tb_interp_view_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_right, btn_down, btn_sel, btn_back;
    logic       interp_ack, interp_done;
    logic       interp_req, start, busy, err;
    logic [9:0] tile_x0, tile_y0;
    logic [3:0] pos_cursor;

    int total = 0;
    int bad   = 0;

    interp_view_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_right  (btn_right),
        .btn_down   (btn_down),
        .btn_sel    (btn_sel),
        .btn_back   (btn_back),
        .interp_req (interp_req),
        .interp_ack (interp_ack),
        .interp_done(interp_done),
        .tile_x0    (tile_x0),
        .tile_y0    (tile_y0),
        .pos_cursor (pos_cursor),
        .start      (start),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mask bits: {back, sel, down, right}
    task automatic press(input logic [3:0] m, input int hold, input int settle);
        {btn_back, btn_sel, btn_down, btn_right} = m;
        repeat (hold) tick();
        {btn_back, btn_sel, btn_down, btn_right} = 4'b0000;
        repeat (settle) tick();
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (interp_req === 1'b1) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic wait_start_low(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (start === 1'b0) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        {btn_back, btn_sel, btn_down, btn_right} = 4'b0000;
        interp_ack = 1'b0; interp_done = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        total++; if (pos_cursor !== 4'd0) begin bad++; $display("FAIL reset_pos got=%0d want=0", pos_cursor); end
        total++; if ({interp_req, start, busy, err} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b want=0000", {interp_req, start, busy, err}); end
        total++; if (tile_x0 !== 10'd0 || tile_y0 !== 10'd0) begin bad++; $display("FAIL reset_tile got=%0d,%0d want=0,0", tile_x0, tile_y0); end
    endtask

    task automatic test_move();
        press(4'b0001, 20, 12);
        total++; if (pos_cursor !== 4'd1) begin bad++; $display("FAIL hold_one_pulse got=%0d want=1", pos_cursor); end
        press(4'b0001, 6, 12);
        total++; if (pos_cursor !== 4'd2) begin bad++; $display("FAIL right_2 got=%0d want=2", pos_cursor); end
        press(4'b0001, 6, 12);
        total++; if (pos_cursor !== 4'd3) begin bad++; $display("FAIL right_3 got=%0d want=3", pos_cursor); end
        press(4'b0001, 6, 12);
        total++; if (pos_cursor !== 4'd0) begin bad++; $display("FAIL right_wrap got=%0d want=0", pos_cursor); end
        // bounces of 3 cycles never reach the 4-sample threshold
        press(4'b0001, 3, 2);
        press(4'b0001, 3, 2);
        press(4'b0010, 3, 12);
        total++; if (pos_cursor !== 4'd0) begin bad++; $display("FAIL bounce got=%0d want=0", pos_cursor); end
    endtask

    task automatic test_ignored_in_select();
        press(4'b1000, 6, 12);
        interp_done = 1'b1; tick(); interp_done = 1'b0; tick();
        total++; if ({start, busy, interp_req} !== 3'b000 || pos_cursor !== 4'd0) begin
            bad++; $display("FAIL select_ignore got=%b pos=%0d want=000 pos=0", {start, busy, interp_req}, pos_cursor);
        end
    endtask

    task automatic test_launch();
        bit ok;
        press(4'b0010, 6, 12);
        press(4'b0010, 6, 12);
        press(4'b0001, 6, 12);
        press(4'b0001, 6, 12);
        press(4'b0001, 6, 12);
        total++; if (pos_cursor !== 4'd11) begin bad++; $display("FAIL pos_11 got=%0d want=11", pos_cursor); end
        press(4'b0100, 6, 0);
        wait_req(ok);
        total++; if (!ok) begin bad++; $display("FAIL sel_req_timeout got=%b want=1", interp_req); end
        total++; if (tile_x0 !== 10'd300 || tile_y0 !== 10'd200) begin bad++; $display("FAIL tile_11 got=%0d,%0d want=300,200", tile_x0, tile_y0); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_launch got=%b want=1", busy); end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (interp_req !== 1'b1 || tile_x0 !== 10'd300) begin bad++; $display("FAIL req_hold%0d got=%b,%0d want=1,300", i, interp_req, tile_x0); end
        end
        interp_ack = 1'b1; tick(); interp_ack = 1'b0;
        total++; if (interp_req !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL ack_drop got=%b%b want=01", interp_req, busy); end
        interp_done = 1'b1; tick(); interp_done = 1'b0;
        total++; if (start !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL show_11 got=%b%b want=10", start, busy); end
        press(4'b1000, 6, 0);
        wait_start_low(ok);
        total++; if (!ok) begin bad++; $display("FAIL back_timeout got=%b want=0", start); end
        press(4'b0010, 6, 12); press(4'b0010, 6, 12); press(4'b0010, 6, 12);
        press(4'b0001, 6, 12); press(4'b0001, 6, 12);
        total++; if (pos_cursor !== 4'd5) begin bad++; $display("FAIL pos_5 got=%0d want=5", pos_cursor); end
    endtask

    task automatic test_coincident_and_show();
        bit ok;
        press(4'b0101, 6, 0);
        wait_req(ok);
        total++; if (!ok) begin bad++; $display("FAIL coinc_req_timeout got=%b want=1", interp_req); end
        total++; if (tile_x0 !== 10'd100 || tile_y0 !== 10'd100) begin bad++; $display("FAIL tile_5 got=%0d,%0d want=100,100", tile_x0, tile_y0); end
        total++; if (pos_cursor !== 4'd5) begin bad++; $display("FAIL coinc_pos got=%0d want=5", pos_cursor); end
        interp_ack = 1'b1; tick(); interp_ack = 1'b0;
        btn_right = 1'b1; btn_down = 1'b1;
        repeat (9) tick();
        total++; if (pos_cursor !== 4'd5 || busy !== 1'b1) begin bad++; $display("FAIL wait_move got=%0d,%b want=5,1", pos_cursor, busy); end
        interp_done = 1'b1; tick(); interp_done = 1'b0;
        btn_right = 1'b0; btn_down = 1'b0;
        total++; if (start !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL done_show got=%b%b want=10", start, busy); end
        repeat (12) tick();
        press(4'b0001, 6, 12);
        total++; if (pos_cursor !== 4'd5 || start !== 1'b1) begin bad++; $display("FAIL show_move got=%0d,%b want=5,1", pos_cursor, start); end
        press(4'b1000, 6, 0);
        wait_start_low(ok);
        total++; if (!ok) begin bad++; $display("FAIL back_timeout2 got=%b want=0", start); end
        total++; if (pos_cursor !== 4'd5 || busy !== 1'b0) begin bad++; $display("FAIL back_pos got=%0d,%b want=5,0", pos_cursor, busy); end
        repeat (12) tick();
    endtask

    task automatic test_timeout();
        bit ok;
        press(4'b0100, 6, 0);
        wait_req(ok);
        total++; if (!ok) begin bad++; $display("FAIL tmo_req_timeout got=%b want=1", interp_req); end
        interp_ack = 1'b1; tick(); interp_ack = 1'b0;
        repeat (63) tick();
        total++; if (err !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL pre_timeout got=%b%b want=01", err, busy); end
        tick();
        total++; if ({err, busy, start, interp_req} !== 4'b1000) begin bad++; $display("FAIL timeout got=%b want=1000", {err, busy, start, interp_req}); end
        repeat (12) tick();
        press(4'b0001, 6, 12);
        total++; if (err !== 1'b1 || pos_cursor !== 4'd6) begin bad++; $display("FAIL err_sticky got=%b,%0d want=1,6", err, pos_cursor); end
        press(4'b0100, 6, 0);
        wait_req(ok);
        total++; if (!ok) begin bad++; $display("FAIL tmo_req_timeout2 got=%b want=1", interp_req); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL sel_clears_err got=%b want=0", err); end
        total++; if (tile_x0 !== 10'd200 || tile_y0 !== 10'd100) begin bad++; $display("FAIL tile_6 got=%0d,%0d want=200,100", tile_x0, tile_y0); end
        interp_ack = 1'b1; tick(); interp_ack = 1'b0;
        repeat (63) tick();
        interp_done = 1'b1; tick(); interp_done = 1'b0;
        total++; if ({start, err, busy} !== 3'b100) begin bad++; $display("FAIL done_wins got=%b want=100", {start, err, busy}); end
        press(4'b1000, 6, 0);
        wait_start_low(ok);
        total++; if (!ok) begin bad++; $display("FAIL back_timeout3 got=%b want=0", start); end
        repeat (12) tick();
    endtask

    task automatic test_reset_mid_launch();
        bit ok;
        press(4'b0100, 6, 0);
        wait_req(ok);
        total++; if (!ok) begin bad++; $display("FAIL rst_req_timeout got=%b want=1", interp_req); end
        reset = 1'b1; tick(); reset = 1'b0;
        total++; if ({interp_req, start, err, busy} !== 4'b0000 || pos_cursor !== 4'd0) begin
            bad++; $display("FAIL reset_mid got=%b,%0d want=0000,0", {interp_req, start, err, busy}, pos_cursor);
        end
        total++; if (tile_x0 !== 10'd0 || tile_y0 !== 10'd0) begin bad++; $display("FAIL reset_mid_tile got=%0d,%0d want=0,0", tile_x0, tile_y0); end
        interp_done = 1'b1; tick(); interp_done = 1'b0; tick();
        total++; if ({start, busy, interp_req} !== 3'b000) begin bad++; $display("FAIL spurious_done got=%b want=000", {start, busy, interp_req}); end
    endtask

    initial begin
        test_reset();
        test_move();
        test_ignored_in_select();
        test_launch();
        test_coincident_and_show();
        test_timeout();
        test_reset_mid_launch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
